// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper.
// Used by the parametrised transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 100 MHz system clock at 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  // Parity over the low data_bits bits: even -> XOR, odd -> XNOR.
  function automatic logic parity_bit(input logic [8:0] data,
                                      input int          data_bits,
                                      input int          mode);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < data_bits) acc ^= data[i];
    end
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; clearing the pointers already discards its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered valid/ready input, configurable
// data width, parity and stop bits, back-to-back frames while data is queued.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  uart_tx_param_if.slave               bus,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  uart_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_d;
  logic                  bit_end;
  logic                  load;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.tx_valid),
    .pop     (load),
    .wdata   (bus.tx_data),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.tx_ready = !fifo_full;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign bit_end      = (cnt_q == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        load  = !fifo_empty;
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == STOP_LAST) begin
            // Chain straight into the next start bit when a word is waiting.
            idx_d   = '0;
            load    = !fifo_empty;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_START;
      shift_d = fifo_rdata;
      par_d   = parity_bit(9'(fifo_rdata), DATA_BITS, PARITY);
      cnt_d   = '0;
      idx_d   = '0;
    end

    // The line is registered, so it is derived from the state being entered.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
    end
  end

endmodule
